// File: rtl/program_loader.sv
// program_loader
//   Receives a byte stream over a valid/ready handshake, assembles 16-bit
//   instructions (high byte first) and writes them sequentially into
//   instruction memory from address 0. The processor is held in reset
//   (CPU_Reset = 1) until a complete, legal program has been loaded.
//
//   Stream: count byte N, then 2N instruction bytes, then (optionally) one
//   checksum byte equal to the XOR of the count byte and all instruction bytes.
//
//   Optional feature macro: LOADER_CHECKSUM_EN (adds CHECK state + checksum).
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-low reset
//   Start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   Byte_In     stream data byte
//   Byte_Valid  Byte_In valid this cycle
//   Byte_Ready  loader accepts a byte this cycle (registered)
//   IM_Wr       instruction-memory write strobe
//   IM_Addr     instruction-memory write address
//   IM_Data     instruction-memory write data
//   CPU_Reset   active-high processor reset, low only when load is done
//   Done        load completed successfully
//   Load_Err    load aborted (sticky until Start or Reset)
//   Word_Count  instructions written so far
module program_loader #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned MAX_WORDS = 128
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [15:0]       IM_Data,
  output logic              CPU_Reset,
  output logic              Done,
  output logic              Load_Err,
  output logic [7:0]        Word_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // Widened by one bit so a MAX_WORDS of 256 would still compare correctly.
  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  state_t     state;
  logic [7:0] n_words;
  logic [7:0] hi_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  logic       xfer;
  logic [7:0] wc_inc;

  assign xfer   = Byte_Valid && Byte_Ready;
  assign wc_inc = Word_Count + 8'd1;

  // Byte_Ready, Done and CPU_Reset are set on the transition into the state
  // they belong to, so they behave as registered decodes of the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      n_words    <= '0;
      hi_byte    <= '0;
      Byte_Ready <= 1'b0;
      IM_Wr      <= 1'b0;
      IM_Addr    <= '0;
      IM_Data    <= '0;
      CPU_Reset  <= 1'b1;
      Done       <= 1'b0;
      Load_Err   <= 1'b0;
      Word_Count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      IM_Wr <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            state      <= S_COUNT;
            Byte_Ready <= 1'b1;
            CPU_Reset  <= 1'b1;
            Done       <= 1'b0;
            Load_Err   <= 1'b0;
            Word_Count <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        S_COUNT: begin
          if (xfer) begin
            n_words <= Byte_In;
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ Byte_In;
`endif
            if (Byte_In == 8'd0 || {1'b0, Byte_In} > MAX_N) begin
              state      <= S_ERR;
              Byte_Ready <= 1'b0;
              Load_Err   <= 1'b1;
            end else begin
              state <= S_HI;
            end
          end
        end

        S_HI: begin
          if (xfer) begin
            hi_byte <= Byte_In;
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ Byte_In;
`endif
            state   <= S_LO;
          end
        end

        S_LO: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum ^ Byte_In;
`endif
            state      <= S_WRITE;
            Byte_Ready <= 1'b0;
            IM_Wr      <= 1'b1;
            IM_Addr    <= ADDR_W'(Word_Count);
            IM_Data    <= {hi_byte, Byte_In};
          end
        end

        S_WRITE: begin
          Word_Count <= wc_inc;
          if (wc_inc == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= S_CHECK;
            Byte_Ready <= 1'b1;
`else
            state      <= S_DONE;
            Done       <= 1'b1;
            CPU_Reset  <= 1'b0;
`endif
          end else begin
            state      <= S_HI;
            Byte_Ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            Byte_Ready <= 1'b0;
            if (Byte_In == csum) begin
              state     <= S_DONE;
              Done      <= 1'b1;
              CPU_Reset <= 1'b0;
            end else begin
              state    <= S_ERR;
              Load_Err <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          Byte_Ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  localparam int ADDR_W    = 7;
  localparam int MAX_WORDS = 128;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset, Start, Byte_Valid;
  logic [7:0]        Byte_In;
  logic              Byte_Ready, IM_Wr, CPU_Reset, Done, Load_Err;
  logic [ADDR_W-1:0] IM_Addr;
  logic [15:0]       IM_Data;
  logic [7:0]        Word_Count;

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .IM_Wr(IM_Wr),
    .IM_Addr(IM_Addr), .IM_Data(IM_Data), .CPU_Reset(CPU_Reset),
    .Done(Done), .Load_Err(Load_Err), .Word_Count(Word_Count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed memory writes and timing
  int unsigned       cyc = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];
  int unsigned       last_wr_cyc, done_cyc, ready_in_wr;
  bit                done_seen;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (IM_Wr === 1'b1) begin
      wr_addr_q.push_back(IM_Addr);
      wr_data_q.push_back(IM_Data);
      last_wr_cyc = cyc;
      if (Byte_Ready === 1'b1) ready_in_wr++;
    end
    if (Done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  // Reference model: stream -> expected writes and final status
  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_data[$];
  bit                exp_done, exp_err;
  logic [7:0]        exp_wc;

  task automatic model_load();
    int n;
    logic [7:0] x;
    n = stream[0];
    exp_addr.delete();
    exp_data.delete();
    if (n == 0 || n > MAX_WORDS) begin
      exp_done = 0; exp_err = 1; exp_wc = 8'd0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(ADDR_W'(i));
        exp_data.push_back({stream[1 + 2*i], stream[2 + 2*i]});
      end
      exp_wc = 8'(n);
      if (CSUM) begin
        x = 8'h00;
        for (int i = 0; i <= 2*n; i++) x = x ^ stream[i];
        exp_done = (stream[2*n + 1] == x);
        exp_err  = !exp_done;
      end else begin
        exp_done = 1; exp_err = 0;
      end
    end
  endtask

  task automatic build_stream(input int n, input bit corrupt);
    logic [7:0] x;
    stream.delete();
    stream.push_back(8'(n));
    if (n != 0 && n <= MAX_WORDS) begin
      x = 8'(n);
      for (int i = 0; i < 2*n; i++) begin
        stream.push_back(8'($urandom));
        x = x ^ stream[stream.size() - 1];
      end
      if (CSUM) stream.push_back(corrupt ? (x ^ 8'(($urandom_range(1, 255)))) : x);
    end
  endtask

  // mode 0: valid held, 1: toggles 1-0-1, 2: random
  task automatic drive_stream(input int mode, input int limit);
    int idx = 0;
    int guard = 0;
    bit v = 1'b0;
    while (idx < limit && guard < 40*limit + 100) begin
      @(negedge Clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = ~v;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      Byte_Valid = v;
      Byte_In    = v ? stream[idx] : 8'($urandom);
      if (v && Byte_Ready === 1'b1) idx++;
      guard++;
    end
    n_checks++;
    if (idx < limit) $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx, limit);
    else n_pass++;
    @(negedge Clk);
    Byte_Valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_seen   = 1'b0;
    ready_in_wr = 0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(Done === 1'b1 || Load_Err === 1'b1) && k < 20) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; Byte_Valid = 1'b0; Byte_In = 8'h00;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    n_checks++; if (CPU_Reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", CPU_Reset); else n_pass++;
    n_checks++; if (Byte_Ready !== 1'b0) $display("FAIL reset_byte_ready: got %b want 0", Byte_Ready); else n_pass++;
    n_checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else n_pass++;
    n_checks++; if (Load_Err !== 1'b0) $display("FAIL reset_load_err: got %b want 0", Load_Err); else n_pass++;
    n_checks++; if ({IM_Addr, IM_Data, Word_Count} !== '0) $display("FAIL reset_regs: addr %h data %h wc %0d want 0", IM_Addr, IM_Data, Word_Count); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 0) $display("FAIL reset_no_write: got %0d writes want 0", wr_addr_q.size()); else n_pass++;
  endtask

  task automatic test_basic_stream(input int mode);
    logic [7:0] w[4];
    w = '{8'h21, 8'hB1, 8'h22, 8'hA2};
    stream.delete();
    stream.push_back(8'h02);
    for (int i = 0; i < 4; i++) stream.push_back(w[i]);
    if (CSUM) stream.push_back(8'h02 ^ 8'h21 ^ 8'hB1 ^ 8'h22 ^ 8'hA2);
    model_load();
    pulse_start();
    drive_stream(mode, stream.size());
    wait_end();
    repeat (2) @(negedge Clk);
    n_checks++; if (wr_addr_q.size() !== 2) $display("FAIL basic%0d_write_count: got %0d want 2", mode, wr_addr_q.size()); else n_pass++;
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL basic%0d_write%0d: got %0d/%h want %0d/%h", mode, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if ({Done, CPU_Reset, Load_Err} !== 3'b100) $display("FAIL basic%0d_status: done/cpu_rst/err got %b%b%b want 100", mode, Done, CPU_Reset, Load_Err); else n_pass++;
    n_checks++; if (Word_Count !== 8'd2) $display("FAIL basic%0d_word_count: got %0d want 2", mode, Word_Count); else n_pass++;
    n_checks++; if (ready_in_wr !== 0) $display("FAIL basic%0d_ready_in_write: got %0d want 0", mode, ready_in_wr); else n_pass++;
    if (mode == 0) begin
      n_checks++;
      if (!done_seen || (done_cyc - last_wr_cyc) !== (CSUM ? 2 : 1))
        $display("FAIL basic_done_latency: got %0d cycles after last write want %0d", done_cyc - last_wr_cyc, CSUM ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_bad_count();
    logic [7:0] bad[2];
    bad = '{8'h00, 8'h81};
    for (int k = 0; k < 2; k++) begin
      stream.delete();
      stream.push_back(bad[k]);
      pulse_start();
      n_checks++; if ({Byte_Ready, Load_Err, Done} !== 3'b100) $display("FAIL badcnt%0d_after_start: ready/err/done got %b%b%b want 100", k, Byte_Ready, Load_Err, Done); else n_pass++;
      drive_stream(0, 1);
      wait_end();
      repeat (3) @(negedge Clk);
      n_checks++; if ({Load_Err, CPU_Reset, Done, Byte_Ready} !== 4'b1100) $display("FAIL badcnt%0d_status: err/cpu_rst/done/ready got %b%b%b%b want 1100", k, Load_Err, CPU_Reset, Done, Byte_Ready); else n_pass++;
      n_checks++; if (wr_addr_q.size() !== 0) $display("FAIL badcnt%0d_no_write: got %0d writes want 0", k, wr_addr_q.size()); else n_pass++;
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    stream = {8'h01, 8'h50, 8'h01, 8'hFF};
    pulse_start();
    drive_stream(0, 4);
    wait_end();
    @(negedge Clk);
    n_checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 0 || wr_data_q[0] !== 16'h5001) $display("FAIL csum_bad_write: got %0d writes want 1 at 0/5001", wr_addr_q.size()); else n_pass++;
    n_checks++; if ({Load_Err, Done, CPU_Reset} !== 3'b101) $display("FAIL csum_bad_status: err/done/cpu_rst got %b%b%b want 101", Load_Err, Done, CPU_Reset); else n_pass++;
    stream = {8'h01, 8'h50, 8'h01, 8'h50};
    pulse_start();
    drive_stream(0, 4);
    wait_end();
    @(negedge Clk);
    n_checks++; if ({Load_Err, Done, CPU_Reset} !== 3'b010) $display("FAIL csum_good_status: err/done/cpu_rst got %b%b%b want 010", Load_Err, Done, CPU_Reset); else n_pass++;
  endtask
`endif

  task automatic test_reset_midload();
    build_stream(5, 1'b0);
    model_load();
    pulse_start();
    drive_stream(0, 6);   // count + words 1,2 + high byte of word 3
    n_checks++; if (wr_addr_q.size() !== 2) $display("FAIL midrst_pre_writes: got %0d want 2", wr_addr_q.size()); else n_pass++;
    #2 Reset = 1'b0;
    #1;
    n_checks++; if ({CPU_Reset, Byte_Ready, Done, IM_Wr} !== 4'b1000) $display("FAIL midrst_outputs: cpu_rst/ready/done/wr got %b%b%b%b want 1000", CPU_Reset, Byte_Ready, Done, IM_Wr); else n_pass++;
    n_checks++; if (Word_Count !== 8'd0) $display("FAIL midrst_word_count: got %0d want 0", Word_Count); else n_pass++;
    @(negedge Clk);
    Reset = 1'b1;
    pulse_start();
    drive_stream(0, stream.size());
    wait_end();
    @(negedge Clk);
    n_checks++; if ({Done, Load_Err, Word_Count} !== {2'b10, 8'd5}) $display("FAIL midrst_reload: done/err %b%b wc %0d want 10 / 5", Done, Load_Err, Word_Count); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 5) $display("FAIL midrst_reload_writes: got %0d want 5", wr_addr_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL midrst_write%0d: got %0d/%h want %0d/%h", i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int n;
    int mode;
    bit corrupt;
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 9))
        0:       n = $urandom_range(129, 255);
        1:       n = 128;
        default: n = $urandom_range(1, 12);
      endcase
      if (it == 0) n = 128;
      if (it == 1) n = 129;
      corrupt = CSUM && ($urandom_range(0, 3) == 0);
      mode    = $urandom_range(0, 2);
      build_stream(n, corrupt);
      model_load();
      pulse_start();
      drive_stream(mode, stream.size());
      wait_end();
      repeat (2) @(negedge Clk);
      n_checks++; if (wr_addr_q.size() !== exp_addr.size()) $display("FAIL rand%0d_write_count: got %0d want %0d (n=%0d)", it, wr_addr_q.size(), exp_addr.size(), n); else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
        n_checks++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]})
          $display("FAIL rand%0d_write%0d: got %0d/%h want %0d/%h", it, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_checks++;
      if ({Done, Load_Err, CPU_Reset} !== {exp_done, exp_err, !exp_done})
        $display("FAIL rand%0d_status: done/err/cpu_rst got %b%b%b want %b%b%b", it, Done, Load_Err, CPU_Reset, exp_done, exp_err, !exp_done);
      else n_pass++;
      n_checks++; if (Word_Count !== exp_wc) $display("FAIL rand%0d_word_count: got %0d want %0d", it, Word_Count, exp_wc); else n_pass++;
      n_checks++; if (ready_in_wr !== 0) $display("FAIL rand%0d_ready_in_write: got %0d want 0", it, ready_in_wr); else n_pass++;
    end
  endtask

  initial begin
    done_seen = 1'b0; ready_in_wr = 0; last_wr_cyc = 0; done_cyc = 0;
    test_reset();
    test_basic_stream(0);
    test_basic_stream(1);
    test_bad_count();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
